// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial add/subtract sequencer built around one external single-bit
//   full-adder cell. Each clock it presents one operand bit pair and a carry
//   to the cell on FaA/FaB/FaC, then shifts the returned FaSum into Result
//   and keeps FaCarry for the next bit. Subtraction is A + ~B + 1.
//
// Ports
//   Clk, Rst        rising-edge clock, synchronous active-high reset
//   Start           request, only accepted while idle
//   Sub             0 = A+B, 1 = A-B (latched with Start)
//   CarryIn         carry-in for add, ignored for subtract
//   OpA, OpB        operands (latched with Start)
//   FaA, FaB, FaC   drive the external full-adder inputs
//   FaSum, FaCarry  outputs of the external full adder
//   Busy            high while an operation is running (ADD and DONE)
//   Done            one-cycle pulse when Result is valid
//   Result          sum/difference modulo 2^WIDTH
//   CarryOut        final carry (subtract: 1 = no borrow)
//   Overflow        signed overflow
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Sub,
  input  logic             CarryIn,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             FaA,
  output logic             FaB,
  output logic             FaC,
  input  logic             FaSum,
  input  logic             FaCarry,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] sha_reg;
  logic [WIDTH-1:0] shb_reg;
  logic             sub_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_out_reg;
  logic             overflow_reg;

  logic in_add;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      sha_reg       <= '0;
      shb_reg       <= '0;
      sub_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Start) begin
            sha_reg   <= OpA;
            shb_reg   <= OpB;
            sub_reg   <= Sub;
            // Subtract is A + ~B + 1, so the initial carry supplies the +1.
            carry_reg <= Sub ? 1'b1 : CarryIn;
            count_reg <= '0;
            state_reg <= S_ADD;
          end
        end

        S_ADD: begin
          // LSB first: after WIDTH shifts the first sum bit reaches bit 0.
          result_reg <= {FaSum, result_reg[WIDTH-1:1]};
          sha_reg    <= sha_reg >> 1;
          shb_reg    <= shb_reg >> 1;
          carry_reg  <= FaCarry;
          if (count_reg == LAST_BIT) begin
            // carry_reg here is the carry into the MSB.
            overflow_reg  <= carry_reg ^ FaCarry;
            carry_out_reg <= FaCarry;
            count_reg     <= '0;
            state_reg     <= S_DONE;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign in_add = (state_reg == S_ADD);

  // Gated so the shared adder cell sees a quiet zero input outside ADD.
  assign FaA = in_add & sha_reg[0];
  assign FaB = in_add & (shb_reg[0] ^ sub_reg);
  assign FaC = in_add & carry_reg;

  assign Busy     = (state_reg == S_ADD) || (state_reg == S_DONE);
  assign Done     = (state_reg == S_DONE);
  assign Result   = result_reg;
  assign CarryOut = carry_out_reg;
  assign Overflow = overflow_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: a combinational full-adder cell closes the
// Fa* loop; directed cases plus randomised operations are checked against
// an arithmetic A+B / A-B reference.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Start = 1'b0;
  logic         Sub = 1'b0;
  logic         CarryIn = 1'b0;
  logic [W-1:0] OpA = '0;
  logic [W-1:0] OpB = '0;
  logic         FaA, FaB, FaC;
  logic         FaSum, FaCarry;
  logic         Busy, Done;
  logic [W-1:0] Result;
  logic         CarryOut, Overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  // Full-adder cell closing the serial loop.
  assign FaSum   = FaA ^ FaB ^ FaC;
  assign FaCarry = (FaA & FaB) | (FaC & (FaA ^ FaB));

  serial_add_ctrl #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Sub      (Sub),
    .CarryIn  (CarryIn),
    .OpA      (OpA),
    .OpB      (OpB),
    .FaA      (FaA),
    .FaB      (FaB),
    .FaC      (FaC),
    .FaSum    (FaSum),
    .FaCarry  (FaCarry),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .CarryOut (CarryOut),
    .Overflow (Overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation; optionally pulses Start (with junk operands) during
  // cycle 3 of ADD and during the DONE cycle, both of which must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input bit pulse);
    logic [W-1:0] bop;
    logic [W:0]   sum;
    logic [W-1:0] exp_res;
    logic         exp_co, exp_ov;
    int           done_cyc, busy_cnt, done_cnt;

    bop     = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, bop} + ((sub || cin) ? (W+1)'(1) : (W+1)'(0));
    exp_res = sum[W-1:0];
    exp_co  = sum[W];
    exp_ov  = (a[W-1] == bop[W-1]) && (exp_res[W-1] != a[W-1]);

    @(negedge Clk);
    OpA = a; OpB = b; Sub = sub; CarryIn = cin; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    OpA = W'($urandom); OpB = W'($urandom);
    Sub = 1'($urandom); CarryIn = 1'($urandom);

    done_cyc = 0; busy_cnt = 0; done_cnt = 0;
    for (int cyc = 1; cyc <= W + 2; cyc++) begin
      if (cyc > 1) @(negedge Clk);
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (cyc <= W) begin
        check("fa_a", 32'(FaA), 32'(a[cyc-1]));
        check("fa_b", 32'(FaB), 32'(b[cyc-1] ^ sub));
      end
      if (cyc == 1) check("fa_c_init", 32'(FaC), 32'(sub | cin));
      if (pulse && (cyc == 3 || cyc == W + 1)) begin
        Start = 1'b1;
        OpA = W'($urandom); OpB = W'($urandom); Sub = 1'($urandom);
      end else begin
        Start = 1'b0;
      end
    end
    check("done_cycle", 32'(done_cyc), 32'(W + 1));
    check("done_count", 32'(done_cnt), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(W + 1));
    check("result", 32'(Result), 32'(exp_res));
    check("carry_out", 32'(CarryOut), 32'(exp_co));
    check("overflow", 32'(Overflow), 32'(exp_ov));
    check("idle_fa", 32'({FaA, FaB, FaC}), 32'd0);
    $display("op a=%02h b=%02h sub=%0d cin=%0d -> res=%02h co=%0d ov=%0d", a, b, sub, cin, Result, CarryOut, Overflow);
  endtask

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic sub; logic cin; } op_t;
  op_t dir [7];

  initial begin
    dir[0] = '{8'h3C, 8'h05, 1'b0, 1'b0};
    dir[1] = '{8'hFF, 8'h01, 1'b0, 1'b0};
    dir[2] = '{8'h7F, 8'h01, 1'b0, 1'b0};
    dir[3] = '{8'h00, 8'h00, 1'b0, 1'b1};
    dir[4] = '{8'h05, 8'h07, 1'b1, 1'b0};
    dir[5] = '{8'h07, 8'h05, 1'b1, 1'b0};
    dir[6] = '{8'h80, 8'h01, 1'b1, 1'b0};

    // Reset state
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_flags", 32'({CarryOut, Overflow}), 32'd0);
    check("rst_fa", 32'({FaA, FaB, FaC}), 32'd0);

    // Directed cases
    foreach (dir[i]) run_op(dir[i].a, dir[i].b, dir[i].sub, dir[i].cin, 1'b0);

    // Start while busy is ignored
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of an add: aborts with no Done
    @(negedge Clk);
    OpA = 8'h55; OpB = 8'h66; Sub = 1'b0; CarryIn = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_result", 32'(Result), 32'd0);
    check("abort_fa", 32'({FaA, FaB, FaC}), 32'd0);
    check("abort_flags", 32'({CarryOut, Overflow}), 32'd0);
    begin
      int seen = 0;
      for (int k = 0; k < W + 4; k++) begin
        @(negedge Clk);
        if (Done || Busy) seen++;
      end
      check("abort_no_done", 32'(seen), 32'd0);
    end
    $display("abort after reset checked");
    run_op(8'hA0, 8'h0B, 1'b0, 1'b0, 1'b0);

    // Randomised operations
    for (int n = 0; n < 500; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
